// File: rtl/instr_fetch_queue.sv
// Registered FIFO between the I-cache response port and decode.
// The head entry is read combinationally; flush empties the queue at the next edge.
module instr_fetch_queue #(
  parameter int          DEPTH     = 4,
  parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [31:0]              in_instr,
  input  logic [31:0]              in_pc,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_instr,
  output logic [31:0]              out_pc,
  output logic [24:0]              out_imm_field,
  input  logic                     flush,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [31:0]      instr_mem_q [DEPTH];
  logic [31:0]      pc_mem_q    [DEPTH];
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push, pop;

  assign in_ready  = (count_q != FULL_CNT);
  assign out_valid = (count_q != '0);
  assign push      = in_valid & in_ready & ~flush;
  assign pop       = out_valid & out_ready & ~flush;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (push) tail_d = tail_q + 1'b1;
      if (pop)  head_d = head_q + 1'b1;
      // push and pop together leave the occupancy unchanged
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Storage holds data only and needs no reset; occupancy qualifies it.
  always_ff @(posedge clock) begin
    if (push) begin
      instr_mem_q[tail_q] <= in_instr;
      pc_mem_q[tail_q]    <= in_pc;
    end
  end

  assign out_instr     = out_valid ? instr_mem_q[head_q] : NOP_INSTR;
  assign out_pc        = out_valid ? pc_mem_q[head_q]    : 32'h0;
  assign out_imm_field = out_instr[31:7];
  assign count         = count_q;

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Directed bench for instr_fetch_queue with immediate-assertion checks.
module tb_instr_fetch_queue;

  logic        clock;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic [24:0] out_imm_field;
  logic        flush;
  logic [2:0]  count;

  int checks = 0;
  int errors = 0;

  instr_fetch_queue #(.DEPTH(4), .NOP_INSTR(32'h00000013)) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_pc(out_pc), .out_imm_field(out_imm_field),
    .flush(flush), .count(count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [31:0] instr_of(input logic [31:0] pc);
    return {pc[11:0], 20'h00093};
  endfunction

  task automatic drive_in(input logic v, input logic [31:0] pc);
    in_valid = v;
    in_pc    = pc;
    in_instr = instr_of(pc);
  endtask

  always @(negedge clock) begin
    if (reset) begin
      checks++;
      assert (count <= 3'd4) else begin
        errors++;
        $error("FAIL count_bound observed=%0d expected<=4", count);
      end
    end
  end

  initial begin
    int s, r, cyc;
    logic acc, popd;

    reset = 1'b0; in_valid = 1'b0; in_instr = 32'h0; in_pc = 32'h0;
    out_ready = 1'b0; flush = 1'b0;

    // Reset then idle
    tick(); tick();
    reset = 1'b1;
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_instr", out_instr, 32'h00000013);
    chk("rst_out_pc", out_pc, 32'h0);
    chk("rst_imm", 32'(out_imm_field), 32'h0000000);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_count", 32'(count), 32'd0);

    // Single pass, no same-cycle bypass
    in_valid = 1'b1; in_instr = 32'hFFF00093; in_pc = 32'h100; out_ready = 1'b1;
    #1;
    chk("single_no_bypass", 32'(out_valid), 32'd0);
    tick();
    in_valid = 1'b0;
    #1;
    chk("single_valid", 32'(out_valid), 32'd1);
    chk("single_pc", out_pc, 32'h100);
    chk("single_instr", out_instr, 32'hFFF00093);
    chk("single_imm", 32'(out_imm_field), 32'h1FFE001);
    chk("single_count1", 32'(count), 32'd1);
    tick();
    chk("single_count0", 32'(count), 32'd0);
    chk("single_empty", 32'(out_valid), 32'd0);

    // Fill and backpressure
    out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      drive_in(1'b1, 32'(4 * k));
      #1;
      chk("fill_ready", 32'(in_ready), 32'd1);
      tick();
    end
    drive_in(1'b1, 32'h10);
    #1;
    chk("full_count", 32'(count), 32'd4);
    chk("full_in_ready", 32'(in_ready), 32'd0);
    chk("full_head_pc", out_pc, 32'h0);
    tick();
    chk("full_hold_count", 32'(count), 32'd4);
    chk("full_hold_pc", out_pc, 32'h0);
    out_ready = 1'b1;
    #1;
    chk("drain_pc0", out_pc, 32'h0);
    tick();
    chk("drain_ready", 32'(in_ready), 32'd1);
    chk("drain_pc4", out_pc, 32'h4);
    tick();
    drive_in(1'b0, 32'h0);
    #1;
    chk("drain_cnt_pp", 32'(count), 32'd3);
    chk("drain_pc8", out_pc, 32'h8);
    tick();
    chk("drain_pcC", out_pc, 32'hC);
    tick();
    chk("drain_pc10", out_pc, 32'h10);
    chk("drain_instr10", out_instr, instr_of(32'h10));
    tick();
    chk("drain_empty", 32'(count), 32'd0);

    // Concurrent push/pop with pointer wrap
    s = 0; r = 0; cyc = 0;
    while ((r < 20) && (cyc < 200)) begin
      drive_in(s < 20, 32'h1000 + 32'(4 * s));
      out_ready = cyc[0];
      #1;
      acc  = in_valid && in_ready;
      popd = out_valid && out_ready;
      if (popd) begin
        chk("stream_pc", out_pc, 32'h1000 + 32'(4 * r));
        chk("stream_instr", out_instr, instr_of(32'h1000 + 32'(4 * r)));
        r++;
      end
      tick();
      if (acc) s++;
      chk("stream_count", 32'(count), 32'(s - r));
      cyc++;
    end
    chk("stream_delivered", 32'(r), 32'd20);
    drive_in(1'b0, 32'h0);
    out_ready = 1'b0;

    // Flush priority
    for (int k = 0; k < 3; k++) begin
      drive_in(1'b1, 32'h300 + 32'(4 * k));
      tick();
    end
    drive_in(1'b0, 32'h0);
    #1;
    chk("pre_flush_count", 32'(count), 32'd3);
    flush = 1'b1; out_ready = 1'b1;
    drive_in(1'b1, 32'h30C);
    tick();
    flush = 1'b0; out_ready = 1'b0;
    drive_in(1'b0, 32'h0);
    #1;
    chk("flush_count", 32'(count), 32'd0);
    chk("flush_valid", 32'(out_valid), 32'd0);
    chk("flush_in_ready", 32'(in_ready), 32'd1);
    chk("flush_nop", out_instr, 32'h00000013);
    flush = 1'b1;
    tick(); tick();
    flush = 1'b0;
    chk("flush_empty_count", 32'(count), 32'd0);
    drive_in(1'b1, 32'h200);
    tick();
    drive_in(1'b0, 32'h0);
    #1;
    chk("post_flush_pc", out_pc, 32'h200);
    chk("post_flush_count", 32'(count), 32'd1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("post_flush_drain", 32'(count), 32'd0);

    // Async reset mid-stream
    drive_in(1'b1, 32'h400); tick();
    drive_in(1'b1, 32'h404); tick();
    drive_in(1'b0, 32'h0);
    #1;
    chk("pre_rst_count", 32'(count), 32'd2);
    reset = 1'b0;
    #1;
    chk("async_valid", 32'(out_valid), 32'd0);
    chk("async_count", 32'(count), 32'd0);
    chk("async_pc", out_pc, 32'h0);
    #1;
    reset = 1'b1;
    tick();
    chk("after_rst_ready", 32'(in_ready), 32'd1);
    chk("after_rst_count", 32'(count), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
